// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard-unit controls,
// the EX redirect, the instruction ROM loop and the decode-side register outputs.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;

  // Surrounding core (hazard unit, EX stage, ROM, decode) drives controls and reads D.
  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD
  );

  // The fetch stage itself.
  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Holds the PC, selects sequential or EX-redirect next PC, and captures
// instruction/PC/PC+4 for decode. All outputs are register outputs.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);

  logic [DATA_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] instr_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_d;
  logic                  valid_d;
  logic                  unused_target_lsbs;

  // Wraps naturally at the top of the address space.
  assign pc_plus4_f = pc_f + DATA_WIDTH'(4);

  // Redirect targets are forced word-aligned; the low bits carry no meaning.
  assign unused_target_lsbs = ^bus.PCTargetE[1:0];

  // PC register: redirect beats stall, stall beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else if (bus.PCSrcE) begin
      pc_f <= {bus.PCTargetE[DATA_WIDTH-1:2], 2'b00};
    end else if (!bus.StallF) begin
      pc_f <= pc_plus4_f;
    end
  end

  // IF/ID register: flush (bubble) beats stall, stall beats capture.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushD) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!bus.StallD) begin
      instr_d    <= bus.InstrF;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

  assign bus.PCF      = pc_f;
  assign bus.InstrD   = instr_d;
  assign bus.PCD      = pc_d;
  assign bus.PCPlus4D = pc_plus4_d;
  assign bus.ValidD   = valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step pushes its expected post-edge
// state to a scoreboard queue, clocks the DUT, then pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    string       tag;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  fetch_stage_if #(.DATA_WIDTH(32)) bus ();

  fetch_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction ROM contents: a recognisable word derived from the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.InstrF = rom(bus.PCF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, queue expected D/PC state, clock, pop and compare.
  task automatic step(input string tag, input logic r, input logic sf, input logic sd,
                      input logic fd, input logic ps, input logic [31:0] tgt,
                      input logic [31:0] e_pcf, input logic [31:0] e_instr,
                      input logic [31:0] e_pcd, input logic e_valid);
    exp_t e;
    exp_t got;
    e.tag   = tag;
    e.pcf   = e_pcf;
    e.instr = e_instr;
    e.pcd   = e_pcd;
    e.pcp4  = e_valid ? e_pcd + 32'd4 : 32'd0;
    e.valid = e_valid;
    sb.push_back(e);
    rst           = r;
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.FlushD    = fd;
    bus.PCSrcE    = ps;
    bus.PCTargetE = tgt;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".PCF"},      bus.PCF,      got.pcf);
    chk({got.tag, ".InstrD"},   bus.InstrD,   got.instr);
    chk({got.tag, ".PCD"},      bus.PCD,      got.pcd);
    chk({got.tag, ".PCPlus4D"}, bus.PCPlus4D, got.pcp4);
    chk({got.tag, ".ValidD"},   {31'd0, bus.ValidD}, {31'd0, got.valid});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0;
    bus.PCSrcE = 1'b0; bus.PCTargetE = '0;
    @(negedge clk);

    // Reset and sequential fetch
    step("rst0", 1, 0, 0, 0, 0, 0, 32'h00, NOP, 32'h00, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 32'h00, NOP, 32'h00, 0);
    step("seq0", 0, 0, 0, 0, 0, 0, 32'h04, rom(32'h00), 32'h00, 1);
    step("seq1", 0, 0, 0, 0, 0, 0, 32'h08, rom(32'h04), 32'h04, 1);
    step("seq2", 0, 0, 0, 0, 0, 0, 32'h0C, rom(32'h08), 32'h08, 1);
    step("seq3", 0, 0, 0, 0, 0, 0, 32'h10, rom(32'h0C), 32'h0C, 1);

    // Full stall at PCF=0x10, then release
    step("stl0", 0, 1, 1, 0, 0, 0, 32'h10, rom(32'h0C), 32'h0C, 1);
    step("stl1", 0, 1, 1, 0, 0, 0, 32'h10, rom(32'h0C), 32'h0C, 1);
    step("stl2", 0, 1, 1, 0, 0, 0, 32'h10, rom(32'h0C), 32'h0C, 1);
    step("rel0", 0, 0, 0, 0, 0, 0, 32'h14, rom(32'h10), 32'h10, 1);
    step("rel1", 0, 0, 0, 0, 0, 0, 32'h18, rom(32'h14), 32'h14, 1);
    step("rel2", 0, 0, 0, 0, 0, 0, 32'h1C, rom(32'h18), 32'h18, 1);
    step("rel3", 0, 0, 0, 0, 0, 0, 32'h20, rom(32'h1C), 32'h1C, 1);

    // Taken branch with flush
    step("br0", 0, 0, 0, 1, 1, 32'h40, 32'h40, NOP, 32'h00, 0);
    step("br1", 0, 0, 0, 0, 0, 0,      32'h44, rom(32'h40), 32'h40, 1);

    // Redirect over stall, unaligned target
    step("rds0", 0, 1, 0, 0, 1, 32'h103, 32'h100, rom(32'h44), 32'h44, 1);
    step("rds1", 0, 0, 0, 0, 0, 0,       32'h104, rom(32'h100), 32'h100, 1);

    // Flush over stall
    step("fls0", 0, 0, 1, 1, 0, 0, 32'h108, NOP, 32'h00, 0);
    step("fls1", 0, 0, 0, 0, 0, 0, 32'h10C, rom(32'h108), 32'h108, 1);

    // StallF alone: D re-captures the same fetch
    step("sf0", 0, 1, 0, 0, 0, 0, 32'h10C, rom(32'h10C), 32'h10C, 1);
    step("sf1", 0, 1, 0, 0, 0, 0, 32'h10C, rom(32'h10C), 32'h10C, 1);
    step("sf2", 0, 0, 0, 0, 0, 0, 32'h110, rom(32'h10C), 32'h10C, 1);

    // Redirect while D stalled, no flush
    step("rsd0", 0, 0, 1, 0, 1, 32'h200, 32'h200, rom(32'h10C), 32'h10C, 1);
    step("rsd1", 0, 0, 0, 0, 0, 0,       32'h204, rom(32'h200), 32'h200, 1);

    // Wrap at top of address space
    step("wr0", 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h00, 0);
    step("wr1", 0, 0, 0, 0, 0, 0, 32'h0000_0000, rom(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
    step("wr2", 0, 0, 0, 0, 0, 0, 32'h0000_0004, rom(32'h0), 32'h0, 1);

    // Reset during a stall
    step("rss0", 0, 1, 1, 0, 0, 0, 32'h04, rom(32'h0), 32'h0, 1);
    step("rss1", 1, 1, 1, 0, 1, 32'h80, 32'h00, NOP, 32'h00, 0);
    step("rss2", 0, 0, 0, 0, 0, 0, 32'h04, rom(32'h0), 32'h0, 1);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
